// File: rtl/nrs_ctrl_param_tx_if.sv
// Handshake and control bundle between the NRS TX controller and its
// surroundings: subframe timing, cinit generator, LFSR pair, NRS buffer.
interface nrs_ctrl_param_tx_if #(
    parameter int RUN_W  = 3,
    parameter int ADDR_W = 4
);
    logic              start;
    logic [RUN_W-1:0]  num_runs;
    logic              abort;
    logic              cinit_valid;
    logic              cinit_run;
    logic              init_x1;
    logic              init_x2;
    logic              shift_x;
    logic              out_valid;
    logic              out_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [RUN_W-1:0]  run_idx;
    logic              busy;
    logic              done;

    // Controller side
    modport master (
        input  start, num_runs, abort, cinit_valid, out_ready,
        output cinit_run, init_x1, init_x2, shift_x, out_valid, wr_en,
               wr_addr, run_idx, busy, done
    );

    // Environment side
    modport slave (
        output start, num_runs, abort, cinit_valid, out_ready,
        input  cinit_run, init_x1, init_x2, shift_x, out_valid, wr_en,
               wr_addr, run_idx, busy, done
    );
endinterface

// File: rtl/nrs_ctrl_param_tx.sv
// NRS Gold-sequence TX controller: sequences cinit/seed/shift/evaluate runs
// per subframe, drives the x1/x2 LFSR controls and the NRS buffer writes.
module nrs_ctrl_param_tx #(
    parameter int NC            = 1600,
    parameter int WORDS_PER_RUN = 4,
    parameter int MAX_RUNS      = 4,
    parameter int RUN_W         = $clog2(MAX_RUNS + 1),
    parameter int ADDR_W        = $clog2(MAX_RUNS * WORDS_PER_RUN)
) (
    input  logic                 clk,
    input  logic                 rst,
    nrs_ctrl_param_tx_if.master  bus
);
    localparam int NUM_SHIFTS = NC - 30;
    localparam int SHIFT_W    = $clog2(NC);
    localparam int WORD_W     = $clog2(WORDS_PER_RUN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_CINIT,
        S_SEED,
        S_SHIFT,
        S_EVAL
    } state_e;

    state_e             r_state;
    state_e             w_next;
    logic [RUN_W-1:0]   r_runs;
    logic [RUN_W-1:0]   r_run_idx;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [SHIFT_W-1:0] r_shift_cnt;
    logic [WORD_W-1:0]  r_word_cnt;
    logic               r_cinit_run;
    logic               r_done;

    logic [RUN_W-1:0]   w_runs_clamped;
    logic               w_accept;
    logic               w_last_word;
    logic               w_last_run;
    logic               w_shift_done;

    // Zero runs means one run; anything above MAX_RUNS saturates.
    assign w_runs_clamped = (bus.num_runs == '0)                  ? RUN_W'(1) :
                            (bus.num_runs > RUN_W'(MAX_RUNS))     ? RUN_W'(MAX_RUNS) :
                                                                    bus.num_runs;
    assign w_accept     = (r_state == S_EVAL) && bus.out_ready;
    assign w_last_word  = w_accept && (r_word_cnt == WORD_W'(WORDS_PER_RUN - 1));
    assign w_last_run   = (r_run_idx == r_runs - RUN_W'(1));
    assign w_shift_done = (r_shift_cnt == SHIFT_W'(NUM_SHIFTS - 1));

    // State register
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state decode; abort overrides everything, including start
    always_comb begin
        // NOTE: default first so no path leaves w_next unassigned (no latch).
        w_next = r_state;
        if (bus.abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:      if (bus.start)       w_next = S_REQ_CINIT;
                S_REQ_CINIT: if (bus.cinit_valid) w_next = S_SEED;
                S_SEED:                           w_next = S_SHIFT;
                S_SHIFT:     if (w_shift_done)    w_next = S_EVAL;
                S_EVAL:      if (w_last_word)     w_next = w_last_run ? S_IDLE : S_REQ_CINIT;
                default:                          w_next = S_IDLE;
            endcase
        end
    end

    // Counters, run bookkeeping and the registered one-cycle pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_runs      <= '0;
            r_run_idx   <= '0;
            r_wr_addr   <= '0;
            r_shift_cnt <= '0;
            r_word_cnt  <= '0;
            r_cinit_run <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            // cinit request fires only on entry into REQ_CINIT
            r_cinit_run <= (w_next == S_REQ_CINIT) && (r_state != S_REQ_CINIT);
            r_done      <= !bus.abort && w_last_word && w_last_run;
            if (bus.abort) begin
                r_run_idx   <= '0;
                r_wr_addr   <= '0;
                r_shift_cnt <= '0;
                r_word_cnt  <= '0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (bus.start) begin
                            r_runs     <= w_runs_clamped;
                            r_run_idx  <= '0;
                            r_wr_addr  <= '0;
                            r_word_cnt <= '0;
                        end
                    end
                    S_SEED:  r_shift_cnt <= '0;
                    S_SHIFT: r_shift_cnt <= r_shift_cnt + SHIFT_W'(1);
                    S_EVAL: begin
                        if (w_accept) begin
                            r_wr_addr <= r_wr_addr + ADDR_W'(1);
                            if (w_last_word) begin
                                r_word_cnt <= '0;
                                if (!w_last_run) r_run_idx <= r_run_idx + RUN_W'(1);
                            end else begin
                                r_word_cnt <= r_word_cnt + WORD_W'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Output decode from the current state
    always_comb begin
        bus.init_x1   = 1'b0;
        bus.init_x2   = 1'b0;
        bus.shift_x   = 1'b0;
        bus.out_valid = 1'b0;
        bus.wr_en     = 1'b0;
        case (r_state)
            S_SEED: begin
                bus.init_x2 = 1'b1;
                bus.init_x1 = (r_run_idx == '0);
            end
            S_SHIFT: bus.shift_x = 1'b1;
            S_EVAL: begin
                bus.out_valid = 1'b1;
                bus.shift_x   = bus.out_ready;
                bus.wr_en     = bus.out_ready;
            end
            default: ;
        endcase
    end

    assign bus.busy      = (r_state != S_IDLE);
    assign bus.cinit_run = r_cinit_run;
    assign bus.done      = r_done;
    assign bus.wr_addr   = r_wr_addr;
    assign bus.run_idx   = r_run_idx;
endmodule

// File: tb/tb_nrs_ctrl_param_tx.sv
// Scoreboard bench for nrs_ctrl_param_tx (NC=64 -> 34 shifts, 4 words/run,
// up to 4 runs). Stimulus pushes expected events; a negedge monitor pops them.
module tb_nrs_ctrl_param_tx;
    localparam int NC     = 64;
    localparam int WPR    = 4;
    localparam int MAXR   = 4;
    localparam int RUN_W  = 3;
    localparam int ADDR_W = 4;
    localparam int RUN_CYCLES = 1 + 1 + (NC - 30) + WPR;  // 40

    typedef enum logic [1:0] {EV_CINIT, EV_SEED, EV_WRITE, EV_DONE} ev_kind_e;
    typedef struct {
        ev_kind_e          kind;
        logic [ADDR_W-1:0] addr;
        logic [RUN_W-1:0]  run;
        logic              x1;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    ev_t  sb[$];
    int   busy_cycles = 0;
    int   shift_cycles = 0;
    int   shift_max = 0;
    int   shift_cur = 0;

    nrs_ctrl_param_tx_if #(.RUN_W(RUN_W), .ADDR_W(ADDR_W)) bus ();

    nrs_ctrl_param_tx #(
        .NC(NC), .WORDS_PER_RUN(WPR), .MAX_RUNS(MAXR), .RUN_W(RUN_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic ev_t mk_ev(ev_kind_e k, int addr, int run, logic x1);
        ev_t e;
        e.kind = k;
        e.addr = ADDR_W'(addr);
        e.run  = RUN_W'(run);
        e.x1   = x1;
        return e;
    endfunction

    // Expected events for one complete run
    task automatic push_run(input int run, input int base);
        sb.push_back(mk_ev(EV_CINIT, 0, run, 1'b0));
        sb.push_back(mk_ev(EV_SEED, 0, run, (run == 0)));
        for (int k = 0; k < WPR; k++) sb.push_back(mk_ev(EV_WRITE, base + k, run, 1'b0));
    endtask

    task automatic push_done();
        sb.push_back(mk_ev(EV_DONE, 0, 0, 1'b0));
    endtask

    task automatic compare_ev(input ev_t act);
        ev_t exp;
        check("sb_event_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("ev_kind", 32'(act.kind), 32'(exp.kind));
            if (exp.kind != EV_DONE)  check("ev_run_idx", 32'(act.run), 32'(exp.run));
            if (exp.kind == EV_WRITE) check("ev_wr_addr", 32'(act.addr), 32'(exp.addr));
            if (exp.kind == EV_SEED)  check("ev_init_x1", 32'(act.x1), 32'(exp.x1));
        end
    endtask

    // Monitor: samples on the falling edge, turns DUT activity into events
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.busy) busy_cycles++;
            if (bus.shift_x) begin
                shift_cycles++;
                shift_cur++;
                if (shift_cur > shift_max) shift_max = shift_cur;
            end else begin
                shift_cur = 0;
            end
            if (bus.cinit_run) compare_ev(mk_ev(EV_CINIT, 0, int'(bus.run_idx), 1'b0));
            if (bus.init_x2)   compare_ev(mk_ev(EV_SEED, 0, int'(bus.run_idx), bus.init_x1));
            if (bus.wr_en)     compare_ev(mk_ev(EV_WRITE, int'(bus.wr_addr), int'(bus.run_idx), 1'b0));
            if (bus.done)      compare_ev(mk_ev(EV_DONE, 0, 0, 1'b0));
        end
    end

    task automatic reset_stats();
        busy_cycles  = 0;
        shift_cycles = 0;
        shift_max    = 0;
    endtask

    // Called just after a rising edge; leaves the bench just after the start edge
    task automatic do_start(input int n);
        bus.num_runs = RUN_W'(n);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 32'(ok), 32'd1);
    endtask

    task automatic check_sb_drained(input string name);
        @(posedge clk); #1;
        check(name, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
        bit seen;

        bus.start       = 1'b0;
        bus.num_runs    = '0;
        bus.abort       = 1'b0;
        bus.cinit_valid = 1'b1;
        bus.out_ready   = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl_outs", 32'({bus.busy, bus.done, bus.cinit_run, bus.init_x1,
                                      bus.init_x2, bus.shift_x, bus.out_valid, bus.wr_en}), 32'd0);
        check("reset_wr_addr", 32'(bus.wr_addr), 32'd0);
        check("reset_run_idx", 32'(bus.run_idx), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: single run, everything always ready
        reset_stats();
        push_run(0, 0);
        push_done();
        do_start(1);
        check("t1_cinit_run_first_cycle", 32'(bus.cinit_run), 32'd1);
        wait_idle(400, "t1_idle_reached");
        check("t1_done_pulse", 32'(bus.done), 32'd1);
        check("t1_busy_cycles", 32'(busy_cycles), 32'(RUN_CYCLES));
        check("t1_shift_consecutive", 32'(shift_max), 32'(NC - 30 + WPR));
        check("t1_wr_addr_end", 32'(bus.wr_addr), 32'd4);
        check_sb_drained("t1_sb_drained");
        check("t1_done_one_cycle", 32'(bus.done), 32'd0);
        check("t1_busy_low", 32'(bus.busy), 32'd0);

        // 2: three runs
        reset_stats();
        for (int r = 0; r < 3; r++) push_run(r, 4 * r);
        push_done();
        do_start(3);
        wait_idle(400, "t2_idle_reached");
        check("t2_busy_cycles", 32'(busy_cycles), 32'(3 * RUN_CYCLES));
        check("t2_shift_total", 32'(shift_cycles), 32'(3 * (NC - 30 + WPR)));
        check("t2_shift_consecutive", 32'(shift_max), 32'(NC - 30 + WPR));
        check("t2_wr_addr_end", 32'(bus.wr_addr), 32'd12);
        check_sb_drained("t2_sb_drained");

        // 3: backpressure pattern during EVAL
        reset_stats();
        push_run(0, 0);
        push_done();
        bus.out_ready = 1'b0;
        do_start(1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.out_valid) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t3_eval_reached", 32'(seen), 32'd1);
        for (int i = 0; i < 7; i++) begin
            bus.out_ready = pat[i][0];
            #1;
            check("t3_out_valid", 32'(bus.out_valid), 32'd1);
            check("t3_wr_en_follows", 32'(bus.wr_en), 32'(pat[i]));
            check("t3_shift_follows", 32'(bus.shift_x), 32'(pat[i]));
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        check("t3_idle_after_4_writes", 32'(bus.busy), 32'd0);
        check("t3_busy_cycles", 32'(busy_cycles), 32'(RUN_CYCLES + 3));
        check_sb_drained("t3_sb_drained");

        // 4: cinit_valid arrives 5 cycles after the request
        reset_stats();
        push_run(0, 0);
        push_done();
        bus.cinit_valid = 1'b0;
        do_start(1);
        for (int i = 0; i < 6; i++) begin
            if (i == 5) bus.cinit_valid = 1'b1;
            #1;
            check("t4_hold_req", 32'({bus.busy, bus.init_x2, bus.shift_x}), 32'b100);
            @(posedge clk); #1;
        end
        check("t4_seed_after_valid", 32'(bus.init_x2), 32'd1);
        wait_idle(400, "t4_idle_reached");
        check("t4_busy_cycles", 32'(busy_cycles), 32'(RUN_CYCLES + 5));
        check_sb_drained("t4_sb_drained");

        // 5: abort in SHIFT of run 1 of 2, simultaneous start blocked, then restart
        push_run(0, 0);
        sb.push_back(mk_ev(EV_CINIT, 0, 1, 1'b0));
        sb.push_back(mk_ev(EV_SEED, 0, 1, 1'b0));
        do_start(2);
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (bus.init_x2 && !bus.init_x1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check("t5_second_seed_seen", 32'(seen), 32'd1);
        repeat (10) @(posedge clk);
        #1;
        check("t5_in_shift_before_abort", 32'(bus.shift_x), 32'd1);
        bus.abort    = 1'b1;
        bus.start    = 1'b1;
        bus.num_runs = RUN_W'(1);
        @(posedge clk); #1;
        check("t5_idle_after_abort", 32'(bus.busy), 32'd0);
        bus.abort = 1'b0;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("t5_start_blocked", 32'(bus.busy), 32'd0);
        check("t5_wr_addr_cleared", 32'(bus.wr_addr), 32'd0);
        check("t5_run_idx_cleared", 32'(bus.run_idx), 32'd0);
        check("t5_sb_drained", 32'(sb.size()), 32'd0);
        reset_stats();
        push_run(0, 0);
        push_done();
        do_start(1);
        wait_idle(400, "t5_restart_idle");
        check("t5_restart_busy_cycles", 32'(busy_cycles), 32'(RUN_CYCLES));
        check_sb_drained("t5_restart_sb_drained");

        // 6a: num_runs=0 behaves as one run
        reset_stats();
        push_run(0, 0);
        push_done();
        do_start(0);
        wait_idle(400, "t6a_idle_reached");
        check("t6a_busy_cycles", 32'(busy_cycles), 32'(RUN_CYCLES));
        check_sb_drained("t6a_sb_drained");

        // 6b: num_runs=7 clamps to 4, address wraps, mid-run start ignored
        reset_stats();
        for (int r = 0; r < MAXR; r++) push_run(r, 4 * r);
        push_done();
        do_start(7);
        repeat (20) @(posedge clk);
        #1;
        bus.num_runs = RUN_W'(1);
        bus.start    = 1'b1;
        @(posedge clk); #1;
        bus.start    = 1'b0;
        wait_idle(800, "t6b_idle_reached");
        check("t6b_busy_cycles", 32'(busy_cycles), 32'(MAXR * RUN_CYCLES));
        check("t6b_wr_addr_wrapped", 32'(bus.wr_addr), 32'd0);
        check_sb_drained("t6b_sb_drained");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/nrs_ctrl_param_tx.md
Name: nrs_ctrl_param_tx

Overview:
Parametrised successor of the TX NRS Gold-sequence control unit. Sequences one or more cinit/seed/shift/evaluate runs per subframe and drives the x1/x2 LFSR datapath and the NRS output buffer. Adds a runtime run count, downstream backpressure on evaluation words, abort, and a done/busy status. Sits between the subframe timing logic and the cinit generator, LFSR pair and NRS RAM.

Parameters:
NC, 1600, Gold sequence offset; SHIFT state lasts NUM_SHIFTS = NC-30 cycles.
WORDS_PER_RUN, 4, evaluation words produced per run (>=1).
MAX_RUNS, 4, maximum runs per subframe.
RUN_W, $clog2(MAX_RUNS+1), width of num_runs.
ADDR_W, $clog2(MAX_RUNS*WORDS_PER_RUN), width of wr_addr.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  pulse; new frame or new subframe; honoured only in IDLE.
num_runs  in  RUN_W  runs for this subframe; latched on accepted start; 0 treated as 1; values >MAX_RUNS clamp to MAX_RUNS.
abort  in  1  level; forces IDLE.
cinit_valid  in  1  cinit generator result ready.
cinit_run  out  1  one-cycle request to the cinit generator.
init_x1  out  1  load x1 LFSR (first run only).
init_x2  out  1  load x2 LFSR with cinit.
shift_x  out  1  advance both LFSRs.
out_valid  out  1  evaluation word available.
out_ready  in  1  downstream accepts the word.
wr_en  out  1  write strobe = out_valid & out_ready.
wr_addr  out  ADDR_W  buffer write address.
run_idx  out  RUN_W  index of the current run.
busy  out  1  high whenever the state is not IDLE.
done  out  1  one-cycle pulse after the last word of the last run.

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0. A reset asserted mid-run takes effect on the next edge; no done pulse is issued.
- States: IDLE, REQ_CINIT, SEED, SHIFT, EVAL.
- IDLE: on start & !abort, latch num_runs (clamped), set run_idx=0 and wr_addr=0, then go to REQ_CINIT.
- REQ_CINIT: cinit_run=1 (registered) only in the first cycle of the state. Go to SEED on the first cycle with cinit_valid=1, including the entry cycle. Wait indefinitely otherwise.
- SEED: one cycle. init_x2=1; init_x1=(run_idx==0). Next state SHIFT.
- SHIFT: shift_x=1 every cycle. Shift counter (width $clog2(NC)) starts at 0 on entry. Go to EVAL after exactly NUM_SHIFTS cycles.
- EVAL: out_valid=1; shift_x=out_ready; wr_en=out_ready.
  - Each accepted word increments wr_addr (wraps modulo 2^ADDR_W) and the word counter.
  - out_ready=0 stalls with no shift and no write.
  - After WORDS_PER_RUN accepted words:
    - If run_idx==latched_runs-1: go to IDLE, with done=1 in the first IDLE cycle.
    - Otherwise: run_idx+1, go to REQ_CINIT.
- Combinational outputs (init_x1/2, shift_x, out_valid, wr_en, busy) decode the current state. cinit_run and done are registered.
- abort=1 in any state: next state IDLE, counters cleared, no done. It also blocks start in the same cycle (abort wins).
- start outside IDLE: ignored; latched num_runs is unaffected.
- Minimum run length with cinit_valid and out_ready always high: 1 + 1 + NUM_SHIFTS + WORDS_PER_RUN cycles.
- cinit_valid outside REQ_CINIT: ignored.

Test Plan:
1. NC=64 (NUM_SHIFTS=34), WORDS_PER_RUN=4, num_runs=1, cinit_valid tied 1, out_ready tied 1, start pulse -> cinit_run 1 cycle, init_x1=init_x2=1 for 1 cycle, shift_x high for 38 consecutive cycles, wr_addr 0..3 with wr_en, done pulses once, wr_addr ends at 4, busy low after done.
2. num_runs=3 -> 3 cinit_run pulses; init_x1 only in the first SEED; wr_addr 0..11 contiguous; run_idx 0,1,2; single done.
3. out_ready toggling 1,0,0,1,1,0,1 in EVAL -> wr_en and shift_x follow out_ready exactly; 4 writes total; state stays EVAL while stalled.
4. cinit_valid delayed 5 cycles after cinit_run -> FSM holds REQ_CINIT 6 cycles; cinit_run not repeated; then SEED.
5. abort mid-SHIFT of run 1 of 2, then start -> IDLE next cycle, no done; restart with wr_addr=0, run_idx=0, init_x1=1.
6. num_runs=0, and separately num_runs=7 with MAX_RUNS=4 -> 1 run (4 words) and 4 runs (16 words, wr_addr wraps to 0) respectively; start during busy is ignored.
